// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - MIPS instruction-fetch stage with IF/ID pipeline register
//
// Purpose:
//   Holds the fetch PC and drives the instruction-memory address. It latches the
//   fetched word into the IF/ID register for decode. It handles load-use stalls,
//   branch/jump redirects that squash IF/ID, and instruction-memory wait states.
//   It also counts the bubbles loaded into IF/ID.
//
// Ports:
//   Clk           in   1   clock, all state changes on rising edge
//   Reset         in   1   synchronous, active-low reset
//   Stall         in   1   hold PC and IF/ID
//   BranchTaken   in   1   redirect fetch to BranchTarget, squash IF/ID
//   BranchTarget  in   32  redirect address, low two bits ignored
//   ImemAddr      out  32  instruction address (equals PC)
//   ImemData      in   32  instruction word at ImemAddr
//   ImemValid     in   1   ImemData valid this cycle (0 = wait state)
//   PC            out  32  current fetch PC
//   ID_Instr      out  32  IF/ID instruction register
//   ID_PCPlus4    out  32  IF/ID copy of fetch PC + 4
//   ID_Valid      out  1   1 = real instruction, 0 = bubble
//   ID_Opcode     out  6   ID_Instr[31:26]
//   ID_Rs         out  5   ID_Instr[25:21]
//   ID_Rt         out  5   ID_Instr[20:16]
//   ID_Rd         out  5   ID_Instr[15:11]
//   ID_Funct      out  6   ID_Instr[5:0]
//   ID_Imm16      out  16  ID_Instr[15:0], feeds the sign extender
//   BubbleCount   out  16  saturating count of bubbles loaded into IF/ID

module if_id_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  output logic [31:0] ImemAddr,
  input  logic [31:0] ImemData,
  input  logic        ImemValid,
  output logic [31:0] PC,
  output logic [31:0] ID_Instr,
  output logic [31:0] ID_PCPlus4,
  output logic        ID_Valid,
  output logic [5:0]  ID_Opcode,
  output logic [4:0]  ID_Rs,
  output logic [4:0]  ID_Rt,
  output logic [4:0]  ID_Rd,
  output logic [5:0]  ID_Funct,
  output logic [15:0] ID_Imm16,
  output logic [15:0] BubbleCount
);

  logic [31:0] pc_plus4;
  logic        bubble_load;

  // Wraps modulo 2^32 naturally.
  assign pc_plus4 = PC + 32'd4;

  // A bubble enters IF/ID on a redirect, or on a memory wait state when not
  // stalled. A stall freezes IF/ID, so it never counts.
  assign bubble_load = BranchTaken | (~Stall & ~ImemValid);

  assign ImemAddr  = PC;
  assign ID_Opcode = ID_Instr[31:26];
  assign ID_Rs     = ID_Instr[25:21];
  assign ID_Rt     = ID_Instr[20:16];
  assign ID_Rd     = ID_Instr[15:11];
  assign ID_Funct  = ID_Instr[5:0];
  assign ID_Imm16  = ID_Instr[15:0];

  // Priority: redirect beats stall, and stall beats fetch or wait.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      PC         <= RESET_PC;
      ID_Instr   <= NOP_INSTR;
      ID_PCPlus4 <= 32'h0000_0000;
      ID_Valid   <= 1'b0;
    end else if (BranchTaken) begin
      // Word fetched this cycle is dropped (no delay slot); ID_PCPlus4 is held.
      PC       <= BranchTarget & ~32'h0000_0003;
      ID_Instr <= NOP_INSTR;
      ID_Valid <= 1'b0;
    end else if (Stall) begin
      // Hold everything; the same PC is refetched after release.
    end else if (ImemValid) begin
      PC         <= pc_plus4;
      ID_Instr   <= ImemData;
      ID_PCPlus4 <= pc_plus4;
      ID_Valid   <= 1'b1;
    end else begin
      ID_Instr <= NOP_INSTR;
      ID_Valid <= 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      BubbleCount <= 16'h0000;
    end else if (bubble_load && (BubbleCount != 16'hFFFF)) begin
      BubbleCount <= BubbleCount + 16'd1;
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - scoreboard testbench for if_id_stage

module tb_if_id_stage;

  logic        Clk;
  logic        Reset;
  logic        Stall;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic [31:0] ImemAddr;
  logic [31:0] ImemData;
  logic        ImemValid;
  logic [31:0] PC;
  logic [31:0] ID_Instr;
  logic [31:0] ID_PCPlus4;
  logic        ID_Valid;
  logic [5:0]  ID_Opcode;
  logic [4:0]  ID_Rs;
  logic [4:0]  ID_Rt;
  logic [4:0]  ID_Rd;
  logic [5:0]  ID_Funct;
  logic [15:0] ID_Imm16;
  logic [15:0] BubbleCount;

  if_id_stage dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .BranchTaken(BranchTaken),
    .BranchTarget(BranchTarget), .ImemAddr(ImemAddr), .ImemData(ImemData),
    .ImemValid(ImemValid), .PC(PC), .ID_Instr(ID_Instr), .ID_PCPlus4(ID_PCPlus4),
    .ID_Valid(ID_Valid), .ID_Opcode(ID_Opcode), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .ID_Rd(ID_Rd), .ID_Funct(ID_Funct), .ID_Imm16(ID_Imm16),
    .BubbleCount(BubbleCount)
  );

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic [15:0] bc;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic cmp(input string tag, input string field, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %h expected %h", tag, field, act, exp);
    end
  endtask

  // Monitor: one sample per cycle, just after the rising edge, popping the
  // expectation queued for that edge.
  initial begin
    exp_t        e;
    logic [31:0] ei;
    forever begin
      @(posedge Clk);
      #1;
      if (q.size() > 0) begin
        e  = q.pop_front();
        ei = e.instr;
        cmp(e.name, "PC", PC, e.pc);
        cmp(e.name, "ImemAddr", ImemAddr, e.pc);
        cmp(e.name, "ID_Instr", ID_Instr, ei);
        cmp(e.name, "ID_PCPlus4", ID_PCPlus4, e.pc4);
        cmp(e.name, "ID_Valid", {31'd0, ID_Valid}, {31'd0, e.valid});
        cmp(e.name, "BubbleCount", {16'd0, BubbleCount}, {16'd0, e.bc});
        cmp(e.name, "ID_Opcode", {26'd0, ID_Opcode}, {26'd0, ei[31:26]});
        cmp(e.name, "ID_Rs", {27'd0, ID_Rs}, {27'd0, ei[25:21]});
        cmp(e.name, "ID_Rt", {27'd0, ID_Rt}, {27'd0, ei[20:16]});
        cmp(e.name, "ID_Rd", {27'd0, ID_Rd}, {27'd0, ei[15:11]});
        cmp(e.name, "ID_Funct", {26'd0, ID_Funct}, {26'd0, ei[5:0]});
        cmp(e.name, "ID_Imm16", {16'd0, ID_Imm16}, {16'd0, ei[15:0]});
      end
    end
  end

  // Drive one cycle of inputs on the falling edge and, if chk, queue the
  // state expected right after the following rising edge.
  task automatic step(input string name, input logic rst, input logic br,
                      input logic st, input logic iv, input logic [31:0] data,
                      input logic [31:0] tgt, input logic chk,
                      input logic [31:0] epc, input logic [31:0] einstr,
                      input logic [31:0] epc4, input logic ev, input logic [15:0] ebc);
    exp_t e;
    @(negedge Clk);
    Reset        = rst;
    BranchTaken  = br;
    Stall        = st;
    ImemValid    = iv;
    ImemData     = data;
    BranchTarget = tgt;
    if (chk) begin
      e.name  = name;
      e.pc    = epc;
      e.instr = einstr;
      e.pc4   = epc4;
      e.valid = ev;
      e.bc    = ebc;
      q.push_back(e);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          drain;
    logic [15:0] ebc;
    Reset = 1'b0; Stall = 1'b0; BranchTaken = 1'b0;
    BranchTarget = 32'h0; ImemData = 32'h0; ImemValid = 1'b0;

    // T1 reset held for two edges, with junk on the other inputs.
    step("t1_rst0", 0, 1, 0, 1, 32'hDEADBEEF, 32'h0000_1234, 1, 32'h0, 32'h0, 32'h0, 0, 16'd0);
    step("t1_rst1", 0, 0, 0, 0, 32'hDEADBEEF, 32'h0, 1, 32'h0, 32'h0, 32'h0, 0, 16'd0);

    // T2 fetch stream.
    step("t2_f0", 1, 0, 0, 1, 32'h2008_0005, 32'h0, 1, 32'h4, 32'h2008_0005, 32'h4, 1, 16'd0);
    step("t2_f1", 1, 0, 0, 1, 32'h2009_FFFF, 32'h0, 1, 32'h8, 32'h2009_FFFF, 32'h8, 1, 16'd0);

    // T3 stall three cycles at PC=8, including a memory wait under stall.
    step("t3_s0", 1, 0, 1, 1, 32'hDEADBEEF, 32'h0, 1, 32'h8, 32'h2009_FFFF, 32'h8, 1, 16'd0);
    step("t3_s1", 1, 0, 1, 0, 32'hDEADBEEF, 32'h0, 1, 32'h8, 32'h2009_FFFF, 32'h8, 1, 16'd0);
    step("t3_s2", 1, 0, 1, 1, 32'hCAFEF00D, 32'h0, 1, 32'h8, 32'h2009_FFFF, 32'h8, 1, 16'd0);
    step("t3_res", 1, 0, 0, 1, 32'h3C01_1234, 32'h0, 1, 32'hC, 32'h3C01_1234, 32'hC, 1, 16'd0);

    // T4 branch beats stall; target low bits masked; ID_PCPlus4 held.
    step("t4_br", 1, 1, 1, 1, 32'h0123_4567, 32'h0000_0043, 1, 32'h40, 32'h0, 32'hC, 0, 16'd1);
    step("t4_wait", 1, 0, 0, 0, 32'h0123_4567, 32'h0, 1, 32'h40, 32'h0, 32'hC, 0, 16'd2);
    step("t4_f", 1, 0, 0, 1, 32'h0109_5020, 32'h0, 1, 32'h44, 32'h0109_5020, 32'h44, 1, 16'd2);

    // T5 wait states then fetch across the 32-bit wrap.
    step("t5_br", 1, 1, 0, 1, 32'h0, 32'hFFFF_FFFE, 1, 32'hFFFF_FFFC, 32'h0, 32'h44, 0, 16'd3);
    step("t5_w0", 1, 0, 0, 0, 32'h0, 32'h0, 1, 32'hFFFF_FFFC, 32'h0, 32'h44, 0, 16'd4);
    step("t5_w1", 1, 0, 0, 0, 32'h0, 32'h0, 1, 32'hFFFF_FFFC, 32'h0, 32'h44, 0, 16'd5);
    step("t5_f", 1, 0, 0, 1, 32'h8C22_0000, 32'h0, 1, 32'h0, 32'h8C22_0000, 32'h0, 1, 16'd5);

    // T6 counter saturation: 65537 wait cycles from a count of 5.
    for (int i = 1; i <= 65537; i++) begin
      ebc = (i >= 65530) ? 16'hFFFF : 16'(5 + i);
      step("t6_sat", 1, 0, 0, 0, 32'h0, 32'h0, (i >= 65528), 32'h0, 32'h0, 32'h0, 0, ebc);
    end
    step("t6_brsat", 1, 1, 0, 0, 32'h0, 32'h0000_0100, 1, 32'h100, 32'h0, 32'h0, 0, 16'hFFFF);
    step("t6_f", 1, 0, 0, 1, 32'h0000_0820, 32'h0, 1, 32'h104, 32'h0000_0820, 32'h104, 1, 16'hFFFF);
    step("t6_st", 1, 0, 1, 1, 32'h1111_1111, 32'h0, 1, 32'h104, 32'h0000_0820, 32'h104, 1, 16'hFFFF);
    // Reset mid-stall, then mid-wait.
    step("t6_rst_st", 0, 0, 1, 1, 32'h1111_1111, 32'h0, 1, 32'h0, 32'h0, 32'h0, 0, 16'd0);
    step("t6_rst_wt", 0, 0, 0, 0, 32'h1111_1111, 32'h0, 1, 32'h0, 32'h0, 32'h0, 0, 16'd0);
    step("t6_after", 1, 0, 0, 1, 32'h2008_0005, 32'h0, 1, 32'h4, 32'h2008_0005, 32'h4, 1, 16'd0);

    drain = 0;
    while (q.size() > 0 && drain < 10) begin
      @(negedge Clk);
      drain++;
    end
    if (q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    @(negedge Clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
